// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared constants and types for the two-source ALU stream arbiter
package alu_arb_pkg;
   localparam int DATA_W_DEF    = 32;
   localparam int BURST_MAX_DEF = 4;
   localparam int CNT_W         = 4;
   typedef enum logic {SRC_ALU0 = 1'b0, SRC_ALU1 = 1'b1} src_t;
endpackage

// File: rtl/alu_arb_oreg.sv
// alu_arb_oreg: single-entry registered output slot with valid/ready handshake
// Ports: clk/rst (sync, active-high); load/load_data (and load_chan when
// ALU_STREAM_ARB_CHANNEL_EN is defined) write the slot; out_valid/out_data
// (and out_chan) come straight from flops; out_ready drains; slot_free tells
// the arbiter a word can be taken this cycle.
module alu_arb_oreg
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
`ifdef ALU_STREAM_ARB_CHANNEL_EN
   input  logic              load_chan,
   output logic              out_chan,
`endif
   output logic              slot_free,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
);
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
`ifdef ALU_STREAM_ARB_CHANNEL_EN
   logic              chan_q, chan_d;
`endif
   always_comb begin
      data_d  = load ? load_data : data_q;
      // a load in the same cycle as a drain keeps the slot occupied
      valid_d = load | (valid_q & ~out_ready);
`ifdef ALU_STREAM_ARB_CHANNEL_EN
      chan_d  = load ? load_chan : chan_q;
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
`ifdef ALU_STREAM_ARB_CHANNEL_EN
         chan_q  <= 1'b0;
`endif
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
`ifdef ALU_STREAM_ARB_CHANNEL_EN
         chan_q  <= chan_d;
`endif
      end
   end
   assign slot_free = ~valid_q | out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;
`ifdef ALU_STREAM_ARB_CHANNEL_EN
   assign out_chan  = chan_q;
`endif
endmodule

// File: rtl/alu_stream_arb.sv
// alu_stream_arb: merges two ALU result streams with burst-limited round-robin
// Ports: clk_clk (clock), reset_reset (sync, active-high); alu0_out_* and
// alu1_out_* are valid/ready source streams; merged_* is the registered
// downstream stream. Defining ALU_STREAM_ARB_CHANNEL_EN adds merged_channel,
// the source index of the word currently on merged_data.
module alu_stream_arb
   import alu_arb_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BURST_MAX = BURST_MAX_DEF
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic [DATA_W-1:0] alu0_out_data,
   input  logic              alu0_out_valid,
   output logic              alu0_out_ready,
   input  logic [DATA_W-1:0] alu1_out_data,
   input  logic              alu1_out_valid,
   output logic              alu1_out_ready,
`ifdef ALU_STREAM_ARB_CHANNEL_EN
   output logic              merged_channel,
`endif
   output logic [DATA_W-1:0] merged_data,
   output logic              merged_valid,
   input  logic              merged_ready
);
   src_t             owner_q, owner_d, gnt_src;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             slot_free, fire;
   logic             below_max;
   always_comb begin
      below_max = cnt_q < CNT_W'(BURST_MAX);
      // grant looks only at state and valids; slot_free merely gates the readies
      gnt_src = (alu0_out_valid & alu1_out_valid)
              ? (below_max ? owner_q : src_t'(~owner_q))
              : (alu1_out_valid ? SRC_ALU1 : SRC_ALU0);
      fire = (alu0_out_valid | alu1_out_valid) & slot_free & ~reset_reset;
      alu0_out_ready = fire & (gnt_src == SRC_ALU0);
      alu1_out_ready = fire & (gnt_src == SRC_ALU1);
      owner_d = fire ? gnt_src : owner_q;
      cnt_d = !fire ? cnt_q
            : (gnt_src != owner_q) ? CNT_W'(1)
            : below_max ? cnt_q + CNT_W'(1) : cnt_q;
   end
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         owner_q <= SRC_ALU0;
         cnt_q   <= '0;
      end else begin
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end
   alu_arb_oreg #(.DATA_W(DATA_W)) u_oreg (
      .clk       (clk_clk),
      .rst       (reset_reset),
      .load      (fire),
      .load_data (gnt_src == SRC_ALU1 ? alu1_out_data : alu0_out_data),
`ifdef ALU_STREAM_ARB_CHANNEL_EN
      .load_chan (gnt_src == SRC_ALU1),
      .out_chan  (merged_channel),
`endif
      .slot_free (slot_free),
      .out_valid (merged_valid),
      .out_data  (merged_data),
      .out_ready (merged_ready)
   );
endmodule

// File: doc/alu_stream_arb.md
ALU_STREAM_ARB -- requirements
Module: alu_stream_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of every data port.
REQ-002 SHALL have parameter BURST_MAX, default 4, max consecutive transfers granted to one source while the other waits; legal range 1..15.
REQ-003 SHALL have port clk_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports alu0_out_data  input  DATA_W and alu0_out_valid  input  1, source 0 stream.
REQ-006 SHALL have port alu0_out_ready  output  1  backpressure to source 0.
REQ-007 SHALL have ports alu1_out_data  input  DATA_W, alu1_out_valid  input  1 and alu1_out_ready  output  1, source 1 stream, same semantics.
REQ-008 SHALL have ports merged_data  output  DATA_W, merged_valid  output  1 and merged_ready  input  1, merged downstream stream.

Function
REQ-009 SHALL transfer on any interface exactly when valid and ready are both 1 at a rising edge.
REQ-010 SHALL hold one registered output entry; merged_data and merged_valid come straight from registers, with no combinational path from inputs.
REQ-011 SHALL report slot free = !merged_valid | merged_ready.
REQ-012 SHALL drive at most one of alu0_out_ready and alu1_out_ready high; grant asserted AND slot free.
REQ-013 SHALL have latency of exactly 1 cycle: a word accepted at edge N appears on merged_data after edge N and stays until the merged handshake.
REQ-014 SHALL keep merged_data and merged_valid stable while merged_valid=1 and merged_ready=0.
REQ-015 SHALL sustain full throughput: with merged_ready held 1, one word per cycle.
REQ-016 SHALL track owner (0/1) and a 4-bit burst_cnt.
REQ-017 SHALL grant as follows when only one source is valid: grant that source.
REQ-018 SHALL, with both valid, grant owner if burst_cnt < BURST_MAX, else the other source.
REQ-019 SHALL grant nothing when neither source is valid; owner and burst_cnt hold.
REQ-020 SHALL, on an input transfer from the owner, increment burst_cnt, saturating at BURST_MAX.
REQ-021 SHALL, on an input transfer from the non-owner, set owner to that source and burst_cnt=1.
REQ-022 SHALL make grant depend only on registered state and current input valids, never on merged_ready; a stalled output blocks both sources without changing owner.
REQ-023 SHALL, with BURST_MAX=1 and both valid, alternate strictly 0,1,0,1.
REQ-024 SHALL ensure simultaneous output drain and input accept in one cycle loads the new word, with merged_valid staying 1.

Reset
REQ-025 SHALL, on reset_reset=1 at an edge, set merged_valid=0, merged_data=0, owner=0, burst_cnt=0, and drive both input readies 0 during reset.
REQ-026 SHALL discard any buffered word on reset asserted mid-operation; merged_valid is 0 the next cycle.
REQ-027 SHALL make source 0 win the first contended grant after reset.

Configuration
REQ-028 SHALL, with macro ALU_STREAM_ARB_CHANNEL_EN defined, add output merged_channel (1 bit), registered with the data, giving the source index of the word.
REQ-029 SHALL, without ALU_STREAM_ARB_CHANNEL_EN, omit the port and its register; all other behaviour identical.

Structure
REQ-030 SHALL place in package alu_arb_pkg: DATA_W default constant, BURST_MAX default constant, the source-index typedef (SRC_ALU0=0, SRC_ALU1=1) and burst-counter width constant.
REQ-031 SHALL implement the output register and its handshake as sub-module alu_arb_oreg; the arbiter and owner/burst state stay in the top.

Verification
REQ-032 SHALL be verified with: only alu0 valid, data 0x11,0x12,0x13, merged_ready=1 -> merged 0x11,0x12,0x13 on consecutive cycles, each 1 cycle after acceptance.
REQ-033 SHALL be verified with: both sources always valid, BURST_MAX=4, merged_ready=1 -> source order 0,0,0,0,1,1,1,1,0, ...
REQ-034 SHALL be verified with: both valid, BURST_MAX=1 -> strict 0,1,0,1 alternation; alu1 data 0xA5A5A5A5 delivered unchanged.
REQ-035 SHALL be verified with: merged_valid=1 holding 0xDEADBEEF, merged_ready=0 for 5 cycles -> data stable, both input readies 0, owner unchanged.
REQ-036 SHALL be verified with: reset_reset pulsed 1 cycle while merged_valid=1 -> merged_valid=0 next cycle, and the first contended grant goes to source 0.
REQ-037 SHALL be verified, with ALU_STREAM_ARB_CHANNEL_EN defined, by mixed traffic -> merged_channel matches the source of every word.
